// File: rtl/uart_top.sv
// uart_top: 8-bit, even-parity, one-stop-bit UART with internal loopback.
// A shared baud generator times both the transmitter and the receiver. The
// transmitter's serial line feeds the receiver directly; there is no pin.
//
// Ports
//   clk              system clock, rising edge
//   rstn             asynchronous active-low reset
//   sel[1:0]         bit time: 00=32, 01=16, 10=8, 11=4 clk cycles
//   tx_start         request to send tx_data_in (accepted only when TX idle)
//   tx_data_in[7:0]  byte to transmit, captured on acceptance
//   rx_data_out[7:0] last byte received
//   parity_bit_error last received frame failed even parity
//   stop_bit_error   last received frame's stop bit sampled 0
//   clk_out          baud clock, one period per bit time
module uart_top (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] sel,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic [7:0] rx_data_out,
  output logic       parity_bit_error,
  output logic       stop_bit_error,
  output logic       clk_out
);

  typedef enum logic [2:0] {
    TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  tx_state_t  tx_state, tx_next;
  rx_state_t  rx_state, rx_next;

  logic [1:0] sel_q;
  logic [1:0] sel_eff;
  logic [5:0] n_bit;
  logic [5:0] n_half;
  logic [5:0] cnt;
  logic       tick;
  logic       both_idle;

  logic [7:0] tx_data;
  logic [2:0] tx_idx;
  logic       serial;

  logic       serial_q;
  logic [5:0] rx_cnt;
  logic [2:0] rx_idx;
  logic [7:0] rx_shift;
  logic       rx_par;
  logic       mid;

  // While both sides are idle the divisor follows sel combinationally (this
  // also covers reset); the registered copy takes over once a frame starts.
  assign both_idle = (tx_state == TX_IDLE) && (rx_state == RX_IDLE);
  assign sel_eff   = both_idle ? sel : sel_q;

  always_comb begin
    n_bit = 6'd4;
    case (sel_eff)
      2'b00:   n_bit = 6'd32;
      2'b01:   n_bit = 6'd16;
      2'b10:   n_bit = 6'd8;
      default: n_bit = 6'd4;
    endcase
  end

  assign n_half  = {1'b0, n_bit[5:1]};
  // ">=" so a shrinking divisor in idle never lets the counter run away.
  assign tick    = (cnt >= n_bit - 6'd1);
  assign clk_out = (cnt >= n_half);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      sel_q <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 6'd1;
      if (both_idle) sel_q <= sel;
    end
  end

  // ---------------- transmitter ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (tx_start) tx_next = TX_WAIT;
      TX_WAIT:   if (tick) tx_next = TX_START;
      TX_START:  if (tick) tx_next = TX_DATA;
      TX_DATA:   if (tick && tx_idx == 3'd7) tx_next = TX_PARITY;
      TX_PARITY: if (tick) tx_next = TX_STOP;
      TX_STOP:   if (tick) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    serial = 1'b1;
    case (tx_state)
      TX_START:  serial = 1'b0;
      TX_DATA:   serial = tx_data[tx_idx];
      TX_PARITY: serial = ^tx_data;
      default:   serial = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data <= '0;
      tx_idx  <= '0;
    end else begin
      if (tx_state == TX_IDLE && tx_start) tx_data <= tx_data_in;
      if (tx_state != TX_DATA)             tx_idx  <= '0;
      else if (tick)                       tx_idx  <= tx_idx + 3'd1;
    end
  end

  // ---------------- receiver ----------------
  // rx_cnt is the position within the current bit. The falling edge is seen
  // one cycle after the line drops, so counting resumes at 1, and the mid-bit
  // sample lands at position N/2 of every bit.
  assign mid = (rx_cnt == n_half);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (serial_q && !serial) rx_next = RX_START;
      RX_START:  if (mid) rx_next = serial ? RX_IDLE : RX_DATA;
      RX_DATA:   if (mid && rx_idx == 3'd7) rx_next = RX_PARITY;
      RX_PARITY: if (mid) rx_next = RX_STOP;
      RX_STOP:   if (mid) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      serial_q         <= 1'b1;
      rx_cnt           <= 6'd1;
      rx_idx           <= '0;
      rx_shift         <= '0;
      rx_par           <= 1'b0;
      rx_data_out      <= '0;
      parity_bit_error <= 1'b0;
      stop_bit_error   <= 1'b0;
    end else begin
      serial_q <= serial;

      if (rx_state == RX_IDLE)          rx_cnt <= 6'd1;
      else if (rx_cnt >= n_bit - 6'd1)  rx_cnt <= '0;
      else                              rx_cnt <= rx_cnt + 6'd1;

      if (rx_state != RX_DATA) rx_idx <= '0;
      else if (mid) begin
        rx_idx   <= rx_idx + 3'd1;
        rx_shift <= {serial, rx_shift[7:1]};
      end

      if (rx_state == RX_PARITY && mid) rx_par <= serial;

      if (rx_state == RX_STOP && mid) begin
        rx_data_out      <= rx_shift;
        parity_bit_error <= (rx_par != ^rx_shift);
        stop_bit_error   <= ~serial;
      end
    end
  end

endmodule

// File: tb/tb_uart_top.sv
// Scoreboard bench for uart_top: stimulus pushes expected frames into a
// queue; an independent monitor pops and compares whenever the receiver
// outputs change outside reset.
module tb_uart_top;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] sel = 2'b11;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic [7:0] rx_data_out;
  logic       parity_bit_error;
  logic       stop_bit_error;
  logic       clk_out;

  always #5 clk = ~clk;

  uart_top dut (
    .clk              (clk),
    .rstn             (rstn),
    .sel              (sel),
    .tx_start         (tx_start),
    .tx_data_in       (tx_data_in),
    .rx_data_out      (rx_data_out),
    .parity_bit_error (parity_bit_error),
    .stop_bit_error   (stop_bit_error),
    .clk_out          (clk_out)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];   // {data, parity_err, stop_err}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: any change of the receiver outputs is a completed frame.
  initial begin : monitor
    logic [9:0] prev_out;
    logic [9:0] cur;
    logic [9:0] expv;
    prev_out = '0;
    forever begin
      @(negedge clk);
      cur = {rx_data_out, parity_bit_error, stop_bit_error};
      if (!rstn) prev_out = '0;
      else if (cur !== prev_out) begin
        prev_out = cur;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected: got %h, expected no new frame", cur);
        end else begin
          expv = exp_q.pop_front();
          check("rx_frame", cur, expv);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data_in = b;
    tx_start   = 1'b1;
    exp_q.push_back({b, 2'b00});
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Cycles between two rising edges of clk_out; -1 if none within the bound.
  task automatic measure_period(output int per);
    int k = 0;
    int first = -1;
    logic last;
    per  = -1;
    last = clk_out;
    while (k < 200 && per < 0) begin
      @(negedge clk);
      k++;
      if (clk_out && !last) begin
        if (first < 0) first = k;
        else per = k - first;
      end
      last = clk_out;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, rx_data_out, 8'h00);
    check({tag, "_parity"}, parity_bit_error, 1'b0);
    check({tag, "_stop"}, stop_bit_error, 1'b0);
    check({tag, "_clk_out"}, clk_out, 1'b0);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int per;
    int k;
    logic [7:0] pat;

    // Reset, then clk_out at 4 cycles/bit: low, high, high, low, low, ...
    rstn = 1'b0;
    sel  = 2'b11;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat = {pat[6:0], clk_out};
    end
    check("clk_out_sel11", pat, 8'b0110_0110);

    // A5 at 4 cycles/bit, must arrive within 48 cycles.
    send(8'hA5);
    wait_drain("latency_a5", 48);
    repeat (20) @(negedge clk);

    // 3C at 32 cycles/bit.
    sel = 2'b00;
    send(8'h3C);
    measure_period(per);
    check("period_sel00", per, 32);
    wait_drain("drain_3c", 400);
    repeat (40) @(negedge clk);

    // Back-to-back: 00 then FF with tx_start held through the first frame.
    sel = 2'b11;
    repeat (4) @(negedge clk);
    tx_data_in = 8'h00;
    tx_start   = 1'b1;
    exp_q.push_back({8'h00, 2'b00});
    exp_q.push_back({8'hFF, 2'b00});
    @(negedge clk);
    tx_data_in = 8'hFF;
    k = 0;
    while (exp_q.size() == 2 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    tx_start = 1'b0;
    wait_drain("drain_b2b", 80);
    repeat (20) @(negedge clk);

    // 81 at 8 cycles/bit, reset asserted mid-DATA.
    sel = 2'b10;
    send(8'h81);
    repeat (24) @(negedge clk);
    exp_q.delete();
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h81);
    wait_drain("drain_81", 120);
    repeat (20) @(negedge clk);

    // sel 11 -> 01 mid-frame: current frame stays at 4, next uses 16.
    sel = 2'b11;
    repeat (4) @(negedge clk);
    send(8'h5A);
    repeat (6) @(negedge clk);
    sel = 2'b01;
    measure_period(per);
    check("period_frozen", per, 4);
    wait_drain("drain_5a", 48);
    repeat (10) @(negedge clk);
    send(8'hC3);
    measure_period(per);
    check("period_sel01", per, 16);
    wait_drain("drain_c3", 250);
    repeat (30) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
